iter_shift_unit: RTL and testbench

// Multi-cycle 32-bit shift/rotate unit in the ALU path; operand bit-reversal is done inside the block.
// SLL is computed as reverse -> logical right shift -> reverse, so one right-shift datapath serves all ops.

---
 rtl/iter_shift_unit.sv | 113 +++++++++++
 tb/tb_iter_shift_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_shift_unit.sv
// Iterative 32-bit shift/rotate unit: one 2^k right-shift stage per cycle, fixed 5-cycle latency.
// SLL is done as reverse -> right shift -> reverse, so a single right-shift datapath serves every op.
module iter_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
);
    localparam int K_W = $clog2(SHAMT_W);
    localparam logic [K_W-1:0] K_LAST = K_W'(SHAMT_W - 1);

    typedef enum logic [1:0] {OP_SRL = 2'b00, OP_SRA = 2'b01, OP_SLL = 2'b10, OP_ROR = 2'b11} op_t;
    typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10} state_t;

    state_t             state;
    logic [K_W-1:0]     k;
    op_t                op;
    logic [SHAMT_W-1:0] shamt;
    logic               fill;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   work_next;
    logic [SHAMT_W-1:0] amt;
    logic               accept;

    function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
        return r;
    endfunction

    // Extending with the fill bit (or a copy of x for rotate) makes shift and rotate one operation.
    function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0]   x,
                                                     input logic [SHAMT_W-1:0] a,
                                                     input logic               f,
                                                     input logic               rot);
        logic [2*WIDTH-1:0] ext;
        ext = rot ? {x, x} : {{WIDTH{f}}, x};
        ext = ext >> a;
        return ext[WIDTH-1:0];
    endfunction

    assign in_ready = (state == IDLE);
    assign accept   = in_ready && in_valid && !flush;
    assign amt      = SHAMT_W'(1) << k;

    always_comb begin
        work_next = work;
        if (shamt[k]) work_next = shift_stage(work, amt, fill, op == OP_ROR);
    end

    // Control path: state, counter and the registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            state     <= IDLE;
            k         <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        k     <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (k == K_LAST) begin
                        k         <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_data  <= (op == OP_SLL) ? bitrev(work_next) : work_next;
                    end else begin
                        k <= k + K_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand registers carry no reset; they are only meaningful between accept and DONE.
    always_ff @(posedge clk) begin
        if (accept) begin
            op    <= op_t'(in_op);
            shamt <= in_shamt;
            fill  <= (op_t'(in_op) == OP_SRA) ? in_data[WIDTH-1] : 1'b0;
            work  <= (op_t'(in_op) == OP_SLL) ? bitrev(in_data) : in_data;
        end else if (state == SHIFT) begin
            work  <= work_next;
        end
    end

endmodule

// File: tb/tb_iter_shift_unit.sv
// Self-checking bench for iter_shift_unit: directed corner cases plus random ops against an arithmetic model.
module tb_iter_shift_unit;
    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    iter_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: ops computed directly with the language shift operators.
    function automatic logic [31:0] ref_model(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o);
        int sh;
        sh = int'(s);
        case (o)
            2'b00:   return d >> sh;
            2'b01:   return 32'($signed(d) >>> sh);
            2'b10:   return d << sh;
            default: return (sh == 0) ? d : ((d >> sh) | (d << (32 - sh)));
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o, input string name);
        logic [31:0] exp;
        int n;
        exp = ref_model(d, s, o);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: in_ready=%b expected 1", name, in_ready);
        end
        in_data = d; in_shamt = s; in_op = o; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0; in_data = $urandom; in_shamt = 5'($urandom); in_op = 2'($urandom);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles expected 5", name, n);
        end
        checks++;
        if (out_data !== exp) begin
            errors++;
            $display("FAIL %s_data: got %h expected %h", name, out_data, exp);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: out_valid=%b in_ready=%b expected 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_shamt = '0; in_op = '0;
        step();
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_data=%h expected 1/0/00000000",
                     in_ready, out_valid, out_data);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_directed();
        run_op(32'h0000_0001, 5'd31, 2'b10, "sll_31");
        run_op(32'h8000_0000, 5'd4,  2'b01, "sra_4");
        run_op(32'h8000_0000, 5'd4,  2'b00, "srl_4");
        run_op(32'h8000_0001, 5'd1,  2'b10, "sll_1");
        run_op(32'h1234_5678, 5'd8,  2'b11, "ror_8");
        run_op(32'hDEAD_BEEF, 5'd0,  2'b00, "srl_0");
        run_op(32'hDEAD_BEEF, 5'd0,  2'b01, "sra_0");
        run_op(32'hDEAD_BEEF, 5'd0,  2'b10, "sll_0");
        run_op(32'hDEAD_BEEF, 5'd0,  2'b11, "ror_0");
        run_op(32'h7FFF_FFFF, 5'd31, 2'b01, "sra_pos31");
        run_op(32'hF000_000F, 5'd31, 2'b11, "ror_31");
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++)
            run_op($urandom, 5'($urandom), 2'($urandom), "random");
    endtask

    task automatic test_backpressure();
        logic [31:0] d, exp;
        logic [4:0]  s;
        logic [1:0]  o;
        int n;
        d = $urandom; s = 5'($urandom_range(1, 31)); o = 2'($urandom);
        exp = ref_model(d, s, o);
        in_data = d; in_shamt = s; in_op = o; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n != 5 || out_data !== exp) begin
            errors++;
            $display("FAIL bp_result: got %h after %0d cycles expected %h after 5", out_data, n, exp);
        end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = ~d; in_shamt = s ^ 5'd1; in_op = o ^ 2'd1;
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: out_valid=%b out_data=%h in_ready=%b expected 1/%h/0",
                         out_valid, out_data, in_ready, exp);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_no_ghost: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush_reset();
        logic [31:0] prev;
        logic        seen;
        prev = out_data;
        in_data = 32'h1357_9BDF; in_shamt = 5'd3; in_op = 2'b00; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== prev) begin
            errors++;
            $display("FAIL flush: in_ready=%b out_valid=%b out_data=%h expected 1/0/%h",
                     in_ready, out_valid, out_data, prev);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_output: out_valid=%b expected 0", seen);
        end
        // flush wins over an accept on the same edge
        in_valid = 1'b1; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_vs_accept: in_ready=%b expected 1", in_ready);
        end
        in_data = 32'h2468_ACE0; in_shamt = 5'd7; in_op = 2'b11; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: in_ready=%b out_valid=%b out_data=%h expected 1/0/00000000",
                     in_ready, out_valid, out_data);
        end
        #3;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_output: out_valid=%b expected 0", seen);
        end
        run_op(32'hF000_0000, 5'd28, 2'b00, "srl_after_reset");
    endtask

    task automatic test_back_to_back();
        logic [31:0] expq[$];
        logic [31:0] d, exp;
        logic [4:0]  s;
        logic [1:0]  o;
        int acc[4];
        int issued, got;
        issued = 0; got = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 80 && got < 4; c++) begin
            if (issued == 4 && in_ready !== 1'b1) in_valid = 1'b0;
            if (out_valid === 1'b1) begin
                checks++;
                exp = (expq.size() > 0) ? expq.pop_front() : 32'hxxxx_xxxx;
                if (out_data !== exp) begin
                    errors++;
                    $display("FAIL b2b_data%0d: got %h expected %h", got, out_data, exp);
                end
                got++;
            end
            if (in_ready === 1'b1 && issued < 4) begin
                d = $urandom; s = 5'($urandom); o = 2'($urandom);
                in_data = d; in_shamt = s; in_op = o; in_valid = 1'b1;
                expq.push_back(ref_model(d, s, o));
                acc[issued] = cyc;
                issued++;
            end
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d results expected 4", got);
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (acc[i] - acc[i-1] != 7) begin
                errors++;
                $display("FAIL b2b_interval%0d: got %0d cycles expected 7", i, acc[i] - acc[i-1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_flush_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
